// File: rtl/button_ctrl_pkg.sv
// Shared types and default timing for the Pong button front end.
// Holds the repeat FSM encoding and the width helpers used by the top and each channel.
package button_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    localparam int DEF_TICK_DIV     = 60000;
    localparam int DEF_DB_TICKS     = 4;
    localparam int DEF_REPEAT_DELAY = 100;
    localparam int DEF_REPEAT_RATE  = 20;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_ctrl_if.sv
// Bundle of the button controller's run enable, raw inputs and pulse outputs.
// All outputs are single-cycle strobes or levels; there is no valid/ready backpressure.
interface button_ctrl_if #(
    parameter int N_BTN = 4
);
    import button_ctrl_pkg::*;

    logic                   i_enable;
    logic [N_BTN-1:0]       i_btn;
    logic                   o_tick;
    logic [N_BTN-1:0]       o_state;
    logic [N_BTN-1:0]       o_press;
    logic [N_BTN-1:0]       o_release;
    logic [N_BTN-1:0]       o_repeat;
    rep_state_t [N_BTN-1:0] o_dbg_state;

    modport slave (
        input  i_enable, i_btn,
        output o_tick, o_state, o_press, o_release, o_repeat, o_dbg_state
    );

    modport master (
        output i_enable, i_btn,
        input  o_tick, o_state, o_press, o_release, o_repeat, o_dbg_state
    );

endinterface

// File: rtl/button_ctrl_btn_channel.sv
// One button: 2-FF synchroniser, tick-based debounce, registered edge pulses
// and the hold-to-repeat FSM.
module btn_channel
    import button_ctrl_pkg::*;
#(
    parameter int DB_TICKS     = DEF_DB_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       tick_i,
    input  logic       btn_i,
    output logic       state_o,
    output logic       press_o,
    output logic       release_o,
    output logic       repeat_o,
    output rep_state_t dbg_state_o
);
    localparam int DW = clog2_min1(DB_TICKS + 1);
    localparam int RW = clog2_min1(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_TICKS - 1);
    localparam logic [RW-1:0] RCNT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RCNT_RATE  = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] RCNT_ONE   = RW'(1);

    logic          sync1_q, sync_q;
    logic          state_q, state_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          press_q, release_q, repeat_q, repeat_d;
    rep_state_t    fsm_q, fsm_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          differ, rise, fall;

    // The flip tick is the DB_TICKS-th consecutive tick on which s differs from state.
    assign differ = sync_q ^ state_q;
    assign rise   = tick_i && differ && !state_q && (db_cnt_q == DB_LAST);
    assign fall   = tick_i && differ &&  state_q && (db_cnt_q == DB_LAST);

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        if (!enable_i) begin
            db_cnt_d = '0;
        end else if (tick_i) begin
            if (!differ) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                state_d  = ~state_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end
    end

    // A debounced fall overrides any repeat expiry on the same tick.
    always_comb begin
        fsm_d    = fsm_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        if (!enable_i || fall) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (rise) begin
                        fsm_d  = DELAY;
                        rcnt_d = RCNT_DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (tick_i) begin
                        if (rcnt_q == RCNT_ONE) begin
                            repeat_d = 1'b1;
                            fsm_d    = REPEAT;
                            rcnt_d   = RCNT_RATE;
                        end else begin
                            rcnt_d = rcnt_q - RW'(1);
                        end
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            fsm_q     <= IDLE;
            rcnt_q    <= '0;
        end else begin
            sync1_q   <= btn_i;
            sync_q    <= sync1_q;
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= repeat_d;
            fsm_q     <= fsm_d;
            rcnt_q    <= rcnt_d;
        end
    end

    assign state_o     = state_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign repeat_o    = repeat_q;
    assign dbg_state_o = fsm_q;

endmodule

// File: rtl/button_ctrl.sv
// Multi-button controller top: one shared sample-tick prescaler feeding
// N_BTN independent debounce/repeat channels.
module button_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int DB_TICKS     = DEF_DB_TICKS,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    button_ctrl_if.slave  bus
);
    localparam int TW = clog2_min1(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic                   tick;
    logic [N_BTN-1:0]       state_v, press_v, release_v, repeat_v;
    rep_state_t [N_BTN-1:0] dbg_v;

    assign tick = bus.i_enable && (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        if (!bus.i_enable || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DB_TICKS     (DB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_ch (
            .clk_i       (i_clk),
            .rst_n_i     (i_rst_n),
            .enable_i    (bus.i_enable),
            .tick_i      (tick),
            .btn_i       (bus.i_btn[g]),
            .state_o     (state_v[g]),
            .press_o     (press_v[g]),
            .release_o   (release_v[g]),
            .repeat_o    (repeat_v[g]),
            .dbg_state_o (dbg_v[g])
        );
    end

    assign bus.o_tick      = tick;
    assign bus.o_state     = state_v;
    assign bus.o_press     = press_v;
    assign bus.o_release   = release_v;
    assign bus.o_repeat    = repeat_v;
    assign bus.o_dbg_state = dbg_v;

endmodule

// File: tb/tb_button_ctrl.sv
// Randomised bench for button_ctrl against a tick/hold-time reference model,
// plus directed latency, glitch, collision, disable and reset scenarios.
module tb_button_ctrl;
    import button_ctrl_pkg::*;

    localparam int N    = 4;
    localparam int TDIV = 4;
    localparam int DB   = 3;
    localparam int RD   = 5;
    localparam int RR   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_ctrl_if #(.N_BTN(N)) bif ();

    button_ctrl #(
        .N_BTN(N), .TICK_DIV(TDIV), .DB_TICKS(DB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles since enable, per-button streak of differing
    // ticks, and number of ticks a press has been held (-1 when not armed).
    int         m_cyc;
    logic [N-1:0] m_s1, m_s, m_state, m_press, m_rel, m_rep;
    int         m_streak[N];
    int         m_held[N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_s1 = '0; m_s = '0; m_state = '0;
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int b = 0; b < N; b++) begin
            m_streak[b] = 0;
            m_held[b]   = -1;
        end
    endtask

    task automatic model_edge();
        logic tk;
        logic [N-1:0] p, r, rp;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tk = bif.i_enable && ((m_cyc % TDIV) == TDIV - 1);
        p = '0; r = '0; rp = '0;
        for (int b = 0; b < N; b++) begin
            if (!bif.i_enable) begin
                m_streak[b] = 0;
                m_held[b]   = -1;
            end else if (tk) begin
                if (m_s[b] != m_state[b]) begin
                    m_streak[b]++;
                    if (m_streak[b] == DB) begin
                        m_state[b]  = ~m_state[b];
                        m_streak[b] = 0;
                        if (m_state[b]) p[b] = 1'b1;
                        else            r[b] = 1'b1;
                    end
                end else begin
                    m_streak[b] = 0;
                end
                if (r[b]) begin
                    m_held[b] = -1;
                end else if (p[b]) begin
                    m_held[b] = 0;
                end else if (m_held[b] >= 0) begin
                    m_held[b]++;
                    if (m_held[b] >= RD && ((m_held[b] - RD) % RR) == 0) rp[b] = 1'b1;
                end
            end
        end
        m_press = p; m_rel = r; m_rep = rp;
        m_s  = m_s1;
        m_s1 = bif.i_btn;
        m_cyc = bif.i_enable ? m_cyc + 1 : 0;
    endtask

    task automatic check_outputs();
        logic exp_tick;
        logic [N-1:0] got_idle, exp_idle;
        exp_tick = rst_n && bif.i_enable && ((m_cyc % TDIV) == TDIV - 1);
        for (int b = 0; b < N; b++) begin
            got_idle[b] = (bif.o_dbg_state[b] == IDLE);
            exp_idle[b] = (m_held[b] < 0);
        end
        check_eq("tick",    32'(bif.o_tick),    32'(exp_tick));
        check_eq("state",   32'(bif.o_state),   32'(m_state));
        check_eq("press",   32'(bif.o_press),   32'(m_press));
        check_eq("release", 32'(bif.o_release), 32'(m_rel));
        check_eq("repeat",  32'(bif.o_repeat),  32'(m_rep));
        check_eq("idle",    32'(got_idle),      32'(exp_idle));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Steps until the chosen pulse (0 press, 1 repeat, 2 release) of button b appears.
    task automatic wait_pulse(input string tag, input int kind, input int b,
                              input int limit, output int cycles);
        logic hit;
        cycles = 0;
        hit    = 1'b0;
        while (!hit && cycles < limit) begin
            step();
            cycles++;
            case (kind)
                0:       hit = bif.o_press[b];
                1:       hit = bif.o_repeat[b];
                default: hit = bif.o_release[b];
            endcase
        end
        if (!hit) check_eq(tag, 32'(0), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int gap;
        int rep_cnt;
        int dur[N];

        bif.i_enable = 1'b0;
        bif.i_btn    = '0;
        rst_n        = 1'b0;
        model_reset();
        repeat (3) step();

        // Reset release with enable high: tick at cycles 3, 7, 11, ...
        bif.i_enable = 1'b1;
        rst_n        = 1'b1;
        repeat (16) step();

        // Clean press, first repeat, steady repeat, then release timed onto an expiry.
        bif.i_btn[0] = 1'b1;
        wait_pulse("press0_timeout", 0, 0, 40, gap);
        check_eq("press0_latency_ok", 32'(gap <= DB * TDIV + 3), 32'(1));
        wait_pulse("repeat1_timeout", 1, 0, 200, gap);
        check_eq("first_repeat_gap", 32'(gap), 32'(RD * TDIV));
        wait_pulse("repeat2_timeout", 1, 0, 200, gap);
        check_eq("repeat_gap", 32'(gap), 32'(RR * TDIV));
        repeat (4) step();
        bif.i_btn[0] = 1'b0;
        wait_pulse("coll_release_timeout", 2, 0, 40, gap);
        check_eq("coll_release_gap", 32'(gap), 32'(12));
        check_eq("coll_no_repeat", 32'(bif.o_repeat[0]), 32'(0));
        step();
        check_eq("coll_fsm_idle", 32'(bif.o_dbg_state[0] == IDLE), 32'(1));

        // Glitch: two ticks high on button 1 must not flip it.
        bif.i_btn[1] = 1'b1;
        repeat (TDIV * 2) step();
        bif.i_btn[1] = 1'b0;
        repeat (30) step();
        check_eq("glitch_state", 32'(bif.o_state[1]), 32'(0));

        // Disable mid-hold, then re-enable while still held.
        bif.i_btn[0] = 1'b1;
        wait_pulse("press_hold_timeout", 0, 0, 40, gap);
        repeat (10) step();
        bif.i_enable = 1'b0;
        repeat (40) step();
        check_eq("disable_state_hold", 32'(bif.o_state[0]), 32'(1));
        check_eq("disable_tick_low", 32'(bif.o_tick), 32'(0));
        bif.i_enable = 1'b1;
        rep_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bif.o_repeat[0]) rep_cnt++;
        end
        check_eq("no_repeat_after_reenable", 32'(rep_cnt), 32'(0));

        // Reset mid-hold: outputs clear at once; the held button re-debounces.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("reset_state_now", 32'(bif.o_state), 32'(0));
        check_eq("reset_pulses_now", 32'(bif.o_press | bif.o_release | bif.o_repeat), 32'(0));
        check_eq("reset_tick_now", 32'(bif.o_tick), 32'(0));
        repeat (3) step();
        rst_n = 1'b1;
        wait_pulse("press_after_reset_timeout", 0, 0, 40, gap);
        check_eq("press_after_reset", 32'(gap), 32'(12));

        // Random phase: independent per-button levels, occasional disable and reset.
        bif.i_btn = '0;
        for (int b = 0; b < N; b++) dur[b] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++) begin
                if (dur[b] == 0) begin
                    bif.i_btn[b] = 1'($urandom_range(0, 1));
                    dur[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10)
                                                         : $urandom_range(20, 120);
                end else begin
                    dur[b]--;
                end
            end
            if (bif.i_enable && $urandom_range(0, 299) == 0) bif.i_enable = 1'b0;
            else if (!bif.i_enable && $urandom_range(0, 29) == 0) bif.i_enable = 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                model_reset();
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
Multi-button input controller for the Pong front end. It shares one prescaled sample tick across N buttons and applies a 2-FF synchroniser and consecutive-tick debounce to each button. It emits registered press and release pulses, plus hold-to-repeat pulses that the paddle logic consumes as step commands.

Parameters:
N_BTN, 4, number of buttons
TICK_DIV, 60000, i_clk cycles per sample tick (5 ms at 12 MHz)
DB_TICKS, 4, consecutive differing ticks needed to flip the debounced state (>=1)
REPEAT_DELAY, 100, ticks from press to the first repeat pulse (>=1)
REPEAT_RATE, 20, ticks between later repeat pulses (>=1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_enable  in  1  run enable
i_btn  in  N_BTN  raw asynchronous button levels, active-high
o_tick  out  1  sample tick, one cycle wide
o_state  out  N_BTN  debounced level
o_press  out  N_BTN  one-cycle pulse on a debounced 0->1 transition
o_release  out  N_BTN  one-cycle pulse on a debounced 1->0 transition
o_repeat  out  N_BTN  one-cycle hold-to-repeat pulse

Behaviour:
- Reset (i_rst_n=0, asynchronous): tick counter=0, synchronisers=0, debounce counters=0, o_state=0, all pulses=0, all FSMs IDLE.
- Synchroniser: i_btn passes through 2 flops every cycle. Call the result s.
- Tick: counter runs 0..TICK_DIV-1 and wraps. o_tick is combinational, high while counter==TICK_DIV-1. Counter width is $clog2(TICK_DIV).
- i_enable=0: tick counter is held at 0 and o_tick=0. Each FSM is forced to IDLE and each debounce counter to 0. o_state holds its value. Pulses are 0.
- Debounce, per button, evaluated only on tick cycles:
  - s!=o_state: counter increments. If the incremented value would equal DB_TICKS, o_state toggles and the counter clears.
  - s==o_state: counter clears, so a glitch shorter than DB_TICKS ticks never changes o_state.
- Pulses are registered on the same edge as the o_state change. o_press/o_release is high exactly in the first cycle where o_state shows its new value.
- Latency from a raw edge to o_state: 2 cycles of synchronisation, plus up to DB_TICKS*TICK_DIV cycles.
- Repeat FSM, per button, with states IDLE, DELAY, REPEAT and a counter rcnt of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - IDLE -> DELAY on the debounced rise; load rcnt=REPEAT_DELAY.
  - DELAY, on tick: if rcnt==1, assert o_repeat next cycle, go to REPEAT and load rcnt=REPEAT_RATE; otherwise decrement rcnt.
  - REPEAT, on tick: if rcnt==1, assert o_repeat and reload REPEAT_RATE; otherwise decrement rcnt.
  - Any state -> IDLE on the debounced fall.
- Simultaneous events: if a fall and an rcnt==1 expiry occur on the same tick, the release wins. o_release=1, o_repeat=0, next state IDLE.
- o_press and o_repeat are never high in the same cycle.
- Buttons are fully independent. Any combination of buttons may pulse in the same cycle.
- Reset asserted mid-hold returns every output to 0 immediately. After reset deasserts, a still-held button needs DB_TICKS fresh ticks before its o_press.

Decomposition:
- Shared package holds the repeat FSM state typedef (IDLE/DELAY/REPEAT, 2-bit encoding) and the default timing constants (TICK_DIV, DB_TICKS, REPEAT_DELAY, REPEAT_RATE).
- One natural sub-module: btn_channel. It contains the synchroniser, debounce counter, edge pulses and repeat FSM for one button, and is instantiated N_BTN times.
- The tick counter stays in the top level and is shared by all channels.

Test Plan (TICK_DIV=4, DB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, N_BTN=4):
- Reset and tick: release i_rst_n with i_enable=1 -> o_tick high every 4th cycle, first at cycle 3. All outputs 0 beforehand.
- Clean press: i_btn[0]=1 held -> o_state[0]=1 and o_press[0]=1 for one cycle at the 3rd tick after s[0] rises. o_release stays 0.
- Glitch: i_btn[1] high for 2 ticks then low -> o_state[1] stays 0 and no pulses.
- Repeat: hold btn0 -> first o_repeat[0] 20 cycles after o_press[0], then every 8 cycles. Release -> o_release[0] after 3 ticks and no further repeats.
- Collision: time the release so the debounced fall lands on the rcnt==1 tick -> o_release=1, o_repeat=0, FSM IDLE.
- Disable and reset mid-hold:
  - i_enable=0 while held -> o_tick=0, o_repeat stops, o_state holds 1.
  - Re-enable -> the next repeat comes only after a fresh debounced press.
  - i_rst_n=0 mid-hold -> all outputs 0 at once. After release, o_press needs 3 ticks.
